// File: rtl/rle_sched.sv
// rle_sched: round-robin frame scheduler sharing one run-length encoder core between NUM_REQ sources.
// Define RLE_SCHED_STATS_EN to add the frame_cnt / trunc_cnt statistics outputs.
module rle_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int CLR_CYC   = 2,
  localparam int IW  = $clog2(NUM_REQ),
  localparam int CW  = $clog2(MAX_WORDS) + 1,
  localparam int CCW = $clog2(CLR_CYC) + 1
) (
  input  logic                      clock,
  input  logic                      sysres,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  input  logic [NUM_REQ-1:0]        src_valid,
  input  logic [NUM_REQ-1:0]        src_last,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [IW-1:0]             frame_src,
  output logic                      busy,
  output logic                      enc_rst_n,
  output logic [DATA_W-1:0]         enc_data,
  output logic                      enc_valid,
  output logic                      enc_last,
  input  logic                      enc_ready,
  input  logic                      enc_done
`ifdef RLE_SCHED_STATS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [7:0]                trunc_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FLUSH} state_t;
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      src_q, src_d, rr_q, rr_d, pick, idx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CCW-1:0]     clr_q, clr_d;
  logic               found, streaming, at_max, xfer;

  always_ff @(posedge clock) begin
    if (!sysres) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      rr_q    <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  // first requester strictly after the last served source, wrapping
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = CLEAR;
        gnt_d   = NUM_REQ'(1) << pick;
        src_d   = pick;
        clr_d   = '0;
      end
      CLEAR: begin
        cnt_d = '0;
        clr_d = clr_q + 1'b1;
        if (clr_q == CCW'(CLR_CYC - 1)) state_d = STREAM;
      end
      STREAM: begin
        if (xfer) cnt_d = cnt_q + 1'b1;
        if (xfer && enc_last) state_d = FLUSH;
      end
      FLUSH: if (enc_done) begin
        state_d = IDLE;
        gnt_d   = '0;
        rr_d    = src_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streaming = state_q == STREAM;
    busy      = state_q != IDLE;
    enc_rst_n = state_q != CLEAR;
    enc_valid = streaming & src_valid[src_q];
    enc_data  = streaming ? src_data[src_q*DATA_W +: DATA_W] : '0;
    at_max    = cnt_q == CW'(MAX_WORDS - 1);
    enc_last  = enc_valid & (src_last[src_q] | at_max);
    src_ready = streaming & enc_ready ? gnt_q : '0;
    xfer      = enc_valid & enc_ready;
  end

  assign gnt       = gnt_q;
  assign frame_src = src_q;

`ifdef RLE_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  trunc_cnt_q, trunc_cnt_d;
  // a truncation is a last word forced by the limit, not by the source
  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'((state_q == FLUSH) & enc_done);
    trunc_cnt_d = trunc_cnt_q + 8'(xfer & enc_last & ~src_last[src_q] & (trunc_cnt_q != 8'hFF));
  end
  always_ff @(posedge clock) begin
    if (!sysres) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end
  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`endif
endmodule
